add_seq_unit: RTL and testbench

ADD_SEQ_UNIT -- requirements
Module: add_seq_unit

---
 rtl/add_seq_unit.sv | 116 +++++++++++
 tb/tb_add_seq_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_seq_unit.sv
// add_seq_unit: multi-cycle adder/subtractor that walks CHUNK bits per clock, LSB slice first.
// Optional feature macro ADD_SEQ_SATURATE_EN clamps signed-overflow results to the extreme value.
module add_seq_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       state_dbg
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // in_ready is high only in IDLE, out_valid only in DONE, so the two never overlap.
  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry;
  logic             signed_r;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last;
  logic [CHUNK-1:0] a_s;
  logic [CHUNK-1:0] b_s;
  logic [CHUNK-1:0] s;
  logic             c_n;
  logic             c_msb;
  logic             ovf_n;
  logic [WIDTH-1:0] res_n;

  assign accept = in_valid & in_ready;
  assign last   = (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)  state_next = CALC;
      CALC:    if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    state_dbg = state;
  end

  // Operand registers shift right so the active slice is always the low CHUNK bits;
  // result shifts in from the top, so after N slices every slice sits in place.
  always_comb begin
    a_s          = a_r[CHUNK-1:0];
    b_s          = b_r[CHUNK-1:0];
    {c_n, s}     = {1'b0, a_s} + {1'b0, b_s} + {{CHUNK{1'b0}}, carry};
    c_msb        = a_s[CHUNK-1] ^ b_s[CHUNK-1] ^ s[CHUNK-1];
    ovf_n        = signed_r & (c_msb ^ c_n);
    res_n        = (result >> CHUNK) | (WIDTH'(s) << (WIDTH - CHUNK));
`ifdef ADD_SEQ_SATURATE_EN
    // A wrapped negative sign means the true value overflowed positive, and vice versa.
    if (last && ovf_n) begin
      res_n = s[CHUNK-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r      <= '0;
      b_r      <= '0;
      carry    <= 1'b0;
      signed_r <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else if (accept) begin
      a_r      <= a;
      b_r      <= op[1] ? ~b : b;
      carry    <= op[1];
      signed_r <= op[0];
      cnt      <= '0;
    end else if (state == CALC) begin
      a_r    <= a_r >> CHUNK;
      b_r    <= b_r >> CHUNK;
      carry  <= c_n;
      cnt    <= cnt + 1'b1;
      result <= res_n;
      if (last) begin
        cout <= c_n;
        ovf  <= ovf_n;
      end
    end
  end

endmodule

// File: tb/tb_add_seq_unit.sv
// tb_add_seq_unit: randomized scoreboard bench for add_seq_unit (32/8) plus two 16-bit builds.
// Expected values come from a plain-arithmetic model; ADD_SEQ_SATURATE_EN is honoured.
module tb_add_seq_unit;
  localparam int W = 32;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic [1:0]   state_dbg;

  logic         iv16;
  logic [1:0]   op16;
  logic [15:0]  a16;
  logic [15:0]  b16;
  logic         ordy16;
  logic         ir16a, ir16b, ov16a, ov16b, c16a, c16b, v16a, v16b;
  logic [15:0]  r16a, r16b;
  logic [1:0]   st16a, st16b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ready_pct = 70;
  int stall    = 0;
  logic [W+1:0] exp_q[$];
  int           acc_q[$];
  logic         ov_prev = 1'b0;

  add_seq_unit #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cout(cout), .ovf(ovf), .state_dbg(state_dbg)
  );

  add_seq_unit #(.WIDTH(16), .CHUNK(16)) dut16_full (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16a), .op(op16),
    .a(a16), .b(b16), .out_valid(ov16a), .out_ready(ordy16), .result(r16a),
    .cout(c16a), .ovf(v16a), .state_dbg(st16a)
  );

  add_seq_unit #(.WIDTH(16), .CHUNK(4)) dut16_nib (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16b), .op(op16),
    .a(a16), .b(b16), .out_valid(ov16b), .out_ready(ordy16), .result(r16b),
    .cout(c16b), .ovf(v16b), .state_dbg(st16b)
  );

  // clock / reset-independent infrastructure
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Reference model: {cout, ovf, result} from ordinary integer arithmetic.
  function automatic logic [W+1:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    longint sx;
    longint sy;
    longint t;
    logic [W-1:0] r;
    logic c;
    logic v;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o[1]) begin
      c = (x >= y);
      t = sx - sy;
      r = x - y;
    end else begin
      c = (64'(x) + 64'(y)) > 64'h0000_0000_FFFF_FFFF;
      t = sx + sy;
      r = x + y;
    end
    v = o[0] && ((t > 64'sd2147483647) || (t < -64'sd2147483648));
`ifdef ADD_SEQ_SATURATE_EN
    if (v) r = (t > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    return {c, v, r};
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Consumer: random out_ready, or forced low for `stall` DONE cycles.
  always @(posedge clk) begin
    #1;
    if (stall > 0) begin
      out_ready = 1'b0;
      if (out_valid) stall--;
    end else begin
      out_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Monitor: compares every DONE cycle against the queue head, pops on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid) begin
        check("in_ready_low_in_done", 64'(in_ready), 64'(0));
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_result: got 0x%0h expected no output", result);
        end else begin
          if (!ov_prev) check("latency", 64'(cyc - acc_q[0]), 64'(N));
          check("cout_ovf_result", 64'({cout, ovf, result}), 64'(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
      ov_prev = out_valid && !out_ready;
    end
  end

  // Drivers: inputs wiggle while busy (must be ignored) and go quiet when the unit is idle.
  task automatic noise();
    if (!in_ready) begin
      in_valid = 1'($urandom_range(0, 1));
      op       = 2'($urandom_range(0, 3));
      a        = $urandom;
      b        = $urandom;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 100) begin
      noise();
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end else begin
      in_valid = 1'b1;
      op = o;
      a  = x;
      b  = y;
      @(posedge clk);
      #1;
      exp_q.push_back(model(o, x, y));
      acc_q.push_back(cyc);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge clk);
      noise();
      g++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run16();
    int la;
    int lb;
    logic [15:0] ra;
    logic [15:0] rb;
    logic ca;
    logic cb;
    la = -1; lb = -1; ra = '0; rb = '0; ca = 1'b1; cb = 1'b1;
    @(negedge clk);
    check("w16_ready_full", 64'(ir16a), 64'(1));
    check("w16_ready_nib", 64'(ir16b), 64'(1));
    op16 = 2'b00; a16 = 16'h1234; b16 = 16'h0FFF; iv16 = 1'b1;
    @(posedge clk);
    #1 iv16 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ov16a && la < 0) begin la = k; ra = r16a; ca = c16a; end
      if (ov16b && lb < 0) begin lb = k; rb = r16b; cb = c16b; end
    end
    check("w16_full_latency", 64'(la), 64'(1));
    check("w16_nib_latency", 64'(lb), 64'(4));
    check("w16_full_result", 64'(ra), 64'h2233);
    check("w16_nib_result", 64'(rb), 64'h2233);
    check("w16_full_cout", 64'(ca), 64'(0));
    check("w16_nib_cout", 64'(cb), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b0;
    iv16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; ordy16 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_result", 64'(result), 64'(0));
    check("reset_cout_ovf", 64'({cout, ovf}), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(in_ready), 64'(1));

    issue(2'b00, 32'hFFFF_FFFF, 32'h0000_0001);
    issue(2'b01, 32'h7FFF_FFFF, 32'h0000_0001);
    issue(2'b11, 32'h8000_0000, 32'h0000_0001);
    issue(2'b10, 32'h0000_0005, 32'h0000_0007);
    drain();

    // Consumer stalls 10 DONE cycles while in_valid toggles.
    stall = 10;
    issue(2'b01, 32'h1234_5678, 32'h0FED_CBA9);
    drain();

    // Reset lands in the second CALC cycle and must discard the operation.
    issue(2'b00, 32'h0000_0001, 32'h0000_0002);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    check("midcalc_reset_out_valid", 64'(out_valid), 64'(0));
    check("midcalc_reset_result", 64'(result), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midcalc_ready_after_release", 64'(in_ready), 64'(1));
    issue(2'b00, 32'd3, 32'd4);
    drain();

    for (int i = 0; i < 60; i++) begin
      ready_pct = (i < 30) ? 100 : 40;
      issue(2'($urandom_range(0, 3)), rnd_operand(), rnd_operand());
    end
    drain();

    run16();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
